// File: rtl/race_timer_pkg.sv
// Shared types and constants for the race_timer BCD timer and its tick divider.
package race_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Preset nibbles outside the decimal range clamp to 9.
    function automatic bcd_t bcd_sat(input logic [3:0] nib);
        return (nib > BCD_MAX) ? BCD_MAX : bcd_t'(nib);
    endfunction

endpackage

// File: rtl/race_tick_gen.sv
// Count-step divider: down-counter that emits one step per TICK_DIV cycles of run.
module race_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic reload,
    input  logic run,
    output logic step
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Holding cnt while run is low lets a resume finish the partial period.
    always_comb begin
        cnt_d = cnt_q;
        step  = 1'b0;
        if (reload) begin
            cnt_d = CNT_RELOAD;
        end else if (run) begin
            if (cnt_q == '0) begin
                cnt_d = CNT_RELOAD;
                step  = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= CNT_RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/race_timer.sv
// N-digit BCD up/down race timer with start/stop/pause control and countdown expiry.
// Optional lap capture register is enabled by defining RACE_TIMER_LAP_EN.
//
// state | meaning
// IDLE  | stopped after reset, clear or load from DONE; mode not yet latched
// RUN   | divider running, digits step once per TICK_DIV cycles
// PAUSE | stopped mid-period, divider value held for resume
// DONE  | countdown reached zero; only clear, load or reset leave
module race_timer
    import race_timer_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int TICK_DIV   = 50_000_000
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    clear,
    input  logic                    count_down,
    input  logic                    load_en,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    running,
    output logic                    tick,
    output logic                    expired,
    output logic                    wrapped
`ifdef RACE_TIMER_LAP_EN
    ,
    input  logic                    lap,
    output logic [4*NUM_DIGITS-1:0] lap_digits
`endif
);

    localparam int W = 4 * NUM_DIGITS;

    timer_state_t state_q, state_d;
    logic [W-1:0] digits_q, digits_d;
    logic         mode_q, mode_d;
    logic         tick_q, tick_d;
    logic         wrapped_q, wrapped_d;

    logic [W-1:0]          inc_val, dec_val, load_sat;
    logic [NUM_DIGITS:0]   carry;
    logic [NUM_DIGITS-1:0] borrow;
    logic                  div_reload, div_run, step;

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_t cur;
        assign cur = digits_q[4*i +: 4];
        assign inc_val[4*i +: 4]  = carry[i]  ? ((cur == BCD_MAX) ? 4'd0 : cur + 4'd1) : cur;
        assign dec_val[4*i +: 4]  = borrow[i] ? ((cur == 4'd0) ? BCD_MAX : cur - 4'd1) : cur;
        assign load_sat[4*i +: 4] = bcd_sat(load_value[4*i +: 4]);
        assign carry[i+1] = carry[i] & (cur == BCD_MAX);
        if (i < NUM_DIGITS - 1) begin : g_borrow
            assign borrow[i+1] = borrow[i] & (cur == 4'd0);
        end
    end

    race_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clock   (clock),
        .reset_n (reset_n),
        .reload  (div_reload),
        .run     (div_run),
        .step    (step)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            digits_q  <= '0;
            mode_q    <= 1'b0;
            tick_q    <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            digits_q  <= digits_d;
            mode_q    <= mode_d;
            tick_q    <= tick_d;
            wrapped_q <= wrapped_d;
        end
    end

    // Priority: clear > load_en > stop > start.
    always_comb begin
        state_d    = state_q;
        digits_d   = digits_q;
        mode_d     = mode_q;
        tick_d     = 1'b0;
        wrapped_d  = 1'b0;
        div_reload = 1'b0;
        div_run    = (state_q == RUN) && !clear && !stop;
        if (clear) begin
            state_d    = IDLE;
            digits_d   = '0;
            mode_d     = 1'b0;
            div_reload = 1'b1;
        end else if (load_en && (state_q != RUN)) begin
            digits_d = load_sat;
            if (state_q == DONE) state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        mode_d     = count_down;
                        div_reload = 1'b1;
                        state_d    = (count_down && (digits_q == '0)) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (step) begin
                        tick_d = 1'b1;
                        if (mode_q) begin
                            digits_d = dec_val;
                            if (dec_val == '0) state_d = DONE;
                        end else begin
                            digits_d  = inc_val;
                            wrapped_d = carry[NUM_DIGITS];
                        end
                    end
                end
                PAUSE: begin
                    if (start && !stop) state_d = RUN;
                end
                DONE: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        running = (state_q == RUN);
        expired = (state_q == DONE);
    end

    assign digits  = digits_q;
    assign tick    = tick_q;
    assign wrapped = wrapped_q;

`ifdef RACE_TIMER_LAP_EN
    logic [W-1:0] lap_q, lap_d;

    // Samples digits_q, so a step on the same edge leaves the pre-step value.
    always_comb begin
        lap_d = lap_q;
        if (clear) begin
            lap_d = '0;
        end else if (lap && ((state_q == RUN) || (state_q == PAUSE))) begin
            lap_d = digits_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lap_q <= '0;
        end else begin
            lap_q <= lap_d;
        end
    end

    assign lap_digits = lap_q;
`endif

endmodule

// File: doc/race_timer.md
# race_timer

Parametrised multi-digit BCD race timer for the race game. It pairs an internal tick divider with an N-digit decimal counter that counts up (elapsed time) or down (countdown). A start/stop/pause state machine controls it, and it raises a completion flag when a countdown reaches zero. Its digit outputs drive the per-digit seven-segment decoders on the top level, in place of the fixed two-digit 1 Hz counter.

## Interface
Parameters:
- NUM_DIGITS, 2: number of BCD digits; legal range 1..8.
- TICK_DIV, 50_000_000: clock cycles per count step (1 Hz at 50 MHz); legal range ≥ 2.

Ports:
- clock  in  1  system clock (CLOCK_50 at top level); the block's only clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level; starts or resumes counting.
- stop  in  1  level; pauses counting.
- clear  in  1  synchronous clear to zero and IDLE.
- count_down  in  1  mode select; 1 = countdown, 0 = count up; latched on leaving IDLE.
- load_en  in  1  loads load_value into the digits.
- load_value  in  4*NUM_DIGITS  BCD preset; digit 0 is in bits [3:0].
- digits  out  4*NUM_DIGITS  current BCD count; digit 0 is least significant.
- running  out  1  high while in RUN.
- tick  out  1  one-cycle pulse on each count step.
- expired  out  1  high while in DONE.
- wrapped  out  1  one-cycle pulse when an up-count rolls over from all 9s to all 0s.

## Operation
- States:
  - IDLE: reset state.
  - RUN.
  - PAUSE.
  - DONE: countdown reached zero.
- Input priority per cycle: clear > load_en > stop > start.
- clear (any state): digits = 0, divider reloads, state becomes IDLE, latched mode = 0.
- load_en:
  - Accepted only in IDLE, PAUSE or DONE; ignored in RUN.
  - Each loaded nibble above 9 saturates to 9.
  - Load from DONE moves the state to IDLE.
- IDLE + start: count_down is latched and the divider reloads to TICK_DIV-1.
  - Countdown mode with digits == 0: go to DONE.
  - Otherwise: go to RUN.
- RUN + stop: go to PAUSE. The divider value is held, so resume completes the partial period.
- PAUSE + start: go to RUN. The divider does not reload.
- DONE: start is ignored. Only clear, load_en or reset leave DONE.
- Divider behaviour in RUN:
  - Decrements each cycle.
  - At 0 it reloads to TICK_DIV-1 and performs one count step.
- Count step, up mode:
  - Ripple-carry BCD increment: a digit at 9 becomes 0 and carries to the next digit.
  - All 9s becomes all 0s and pulses wrapped; counting continues.
- Count step, down mode:
  - BCD decrement: a digit at 0 becomes 9 and borrows from the next digit.
  - A step that produces all zeros moves to DONE.
- start and stop asserted together: stop wins, so RUN goes to PAUSE and IDLE/PAUSE do not move.

## Timing
- Reset values: digits = 0, running = 0, tick = 0, expired = 0, wrapped = 0, state = IDLE, divider = TICK_DIV-1, latched mode = 0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Start latency:
  - running rises on the edge that samples start in IDLE or PAUSE.
  - From IDLE, the first count step occurs exactly TICK_DIV cycles after that edge.
- On a count step edge, the new digits value and tick = 1 appear together for one cycle; wrapped also appears on that edge.
- Countdown reaching zero: on the same edge as that step, expired goes to 1 and running goes to 0.
- stop: running falls on the edge that samples stop, and no count step occurs on that edge.
- clear and load_en take effect on the sampling edge; tick and wrapped are forced to 0 that cycle.
- Reset asserted mid-count returns all state to reset values immediately, independent of clock.

## Configuration
- RACE_TIMER_LAP_EN:
  - Defined: adds input lap (1 bit) and output lap_digits (4*NUM_DIGITS, reset 0).
  - lap high in RUN or PAUSE captures digits into lap_digits on the sampling edge. If a count step happens on that same edge, the pre-step value is captured.
  - lap_digits clears on clear.
  - Undefined: neither port exists and no capture register is synthesised.

## Structure
- Package race_timer_pkg holds:
  - state enum timer_state_t {IDLE, RUN, PAUSE, DONE};
  - bcd_t, a 4-bit digit type;
  - constant BCD_MAX = 4'd9.
- One sub-module, race_tick_gen:
  - Parameter TICK_DIV; inputs clock, reset_n, reload, run; output step.
  - Holds the down-counter and reload logic.
- The BCD increment/decrement chain is a generate loop over NUM_DIGITS in race_timer.

## Test plan
- NUM_DIGITS=2, TICK_DIV=4, up mode: start held → tick every 4 cycles; after 100 steps digits return 00 with one wrapped pulse (98→99→00).
- Down mode, load 0x05, start → after 5 steps digits = 00, expired = 1, running = 0; further start is ignored.
- Down mode, load 0x00, start → DONE on the next edge, no tick.
- Pause/resume, TICK_DIV=4: stop 2 cycles into a period, hold 10 cycles, start → next step exactly 2 cycles after resume.
- start and stop together in RUN → PAUSE; clear with load_en together → digits 00, IDLE; load 0xFA in IDLE → digits 0x99.
- Reset asserted mid-count at digits 0x37 → outputs go to reset values immediately. With RACE_TIMER_LAP_EN, lap at 0x12 → lap_digits = 0x12 while digits keep counting.
